// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream core.
// Holds the controller state encoding and the S-box depth.
package rc4_pkg;

    localparam int SBOX_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA_J,
        KSA_SWAP,
        PRGA_IJ,
        PRGA_SWAP,
        PRGA_T,
        PRGA_OUT
    } rc4_state_e;

endpackage

// File: rtl/rc4_sbox.sv
// 256x8 RC4 permutation store: identity load, three combinational reads,
// and a two-address swap whose writes land on the same edge.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       init,
    input  logic       swap_en,
    input  logic [7:0] swap_a,
    input  logic [7:0] swap_b,
    input  logic [7:0] rd_i_addr,
    input  logic [7:0] rd_j_addr,
    input  logic [7:0] rd_t_addr,
    output logic [7:0] rd_i_data,
    output logic [7:0] rd_j_data,
    output logic [7:0] rd_t_data
);

    logic [7:0] mem_q [SBOX_DEPTH];
    logic [7:0] mem_d [SBOX_DEPTH];

    // Swap reads only mem_q, so a==b degenerates to a harmless self-write.
    always_comb begin
        mem_d = mem_q;
        if (init) begin
            for (int n = 0; n < SBOX_DEPTH; n++) begin
                mem_d[n] = 8'(n);
            end
        end else if (swap_en) begin
            mem_d[swap_a] = mem_q[swap_b];
            mem_d[swap_b] = mem_q[swap_a];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_i_data = mem_q[rd_i_addr];
    assign rd_j_data = mem_q[rd_j_addr];
    assign rd_t_data = mem_q[rd_t_addr];

endmodule

// File: rtl/rc4_stream_core.sv
// RC4 keystream generator: byte-serial key load, drop-n discard,
// counted or free-running output over a valid/ready handshake.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | waiting for start; key writes accepted
// INIT      | load identity permutation, clear i/j/kidx
// KSA_J     | j += S[i] + K[kidx]
// KSA_SWAP  | swap S[i],S[j]; advance i and kidx; leave after i==255
// PRGA_IJ   | i += 1; j += S[i+1]
// PRGA_SWAP | swap S[i],S[j]; t = S[i]+S[j] from pre-swap values
// PRGA_T    | burn one dropped byte, or present S[t] on the output
// PRGA_OUT  | hold byte until accepted; finish when count reached
module rc4_stream_core
    import rc4_pkg::*;
#(
    parameter int KEY_MAX_BYTES = 16,
    parameter int CNT_W         = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             key_we,
    input  logic [$clog2(KEY_MAX_BYTES)-1:0] key_waddr,
    input  logic [7:0]                       key_wdata,
    input  logic [8:0]                       key_len,
    input  logic [CNT_W-1:0]                 drop_n,
    input  logic [CNT_W-1:0]                 num_bytes,
    input  logic                             start,
    input  logic                             abort,
    output logic                             ks_valid,
    input  logic                             ks_ready,
    output logic [7:0]                       ks_byte,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int                KW       = $clog2(KEY_MAX_BYTES);
    localparam logic [KW-1:0]     KIDX_ONE = KW'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    rc4_state_e         state_q, state_d;
    logic [7:0]         i_q, i_d;
    logic [7:0]         j_q, j_d;
    logic [7:0]         t_q, t_d;
    logic [KW-1:0]      kidx_q, kidx_d;
    logic [8:0]         key_len_q, key_len_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         key_q [KEY_MAX_BYTES];
    logic [7:0]         key_d [KEY_MAX_BYTES];
    logic               ks_valid_q, ks_valid_d;
    logic [7:0]         ks_byte_q, ks_byte_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [7:0]         key_byte;
    logic [7:0]         rd_i_addr;
    logic               sbox_init;
    logic               sbox_swap;
    logic [7:0]         s_i, s_j, s_t;
    logic               start_bad;

    rc4_sbox u_sbox (
        .clk       (clk),
        .init      (sbox_init),
        .swap_en   (sbox_swap),
        .swap_a    (i_q),
        .swap_b    (j_q),
        .rd_i_addr (rd_i_addr),
        .rd_j_addr (j_q),
        .rd_t_addr (t_q),
        .rd_i_data (s_i),
        .rd_j_data (s_j),
        .rd_t_data (s_t)
    );

    assign key_byte  = key_q[kidx_q];
    assign start_bad = (key_len == 9'd0) || (key_len > 9'(KEY_MAX_BYTES));

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        t_d        = t_q;
        kidx_d     = kidx_q;
        key_len_d  = key_len_q;
        drop_d     = drop_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        ks_valid_d = ks_valid_q;
        ks_byte_d  = ks_byte_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rd_i_addr  = i_q;
        sbox_init  = 1'b0;
        sbox_swap  = 1'b0;

        // Key is frozen outside IDLE so the schedule sees one consistent key.
        if (key_we && (state_q == IDLE) && (int'(key_waddr) < KEY_MAX_BYTES)) begin
            key_d[key_waddr] = key_wdata;
        end

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            ks_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (start_bad) begin
                            err_d = 1'b1;
                        end else begin
                            key_len_d = key_len;
                            drop_d    = drop_n;
                            num_d     = num_bytes;
                            cnt_d     = '0;
                            state_d   = INIT;
                        end
                    end
                end
                INIT: begin
                    sbox_init = 1'b1;
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    kidx_d    = '0;
                    state_d   = KSA_J;
                end
                KSA_J: begin
                    j_d     = j_q + s_i + key_byte;
                    state_d = KSA_SWAP;
                end
                KSA_SWAP: begin
                    sbox_swap = 1'b1;
                    // Wrap compare replaces i mod key_len.
                    if (9'(kidx_q) == (key_len_q - 9'd1)) begin
                        kidx_d = '0;
                    end else begin
                        kidx_d = kidx_q + KIDX_ONE;
                    end
                    if (i_q == 8'hFF) begin
                        i_d     = 8'd0;
                        j_d     = 8'd0;
                        state_d = PRGA_IJ;
                    end else begin
                        i_d     = i_q + 8'd1;
                        state_d = KSA_J;
                    end
                end
                PRGA_IJ: begin
                    rd_i_addr = i_q + 8'd1;
                    i_d       = i_q + 8'd1;
                    j_d       = j_q + s_i;
                    state_d   = PRGA_SWAP;
                end
                PRGA_SWAP: begin
                    sbox_swap = 1'b1;
                    t_d       = s_i + s_j;
                    state_d   = PRGA_T;
                end
                PRGA_T: begin
                    if (drop_q != '0) begin
                        drop_d  = drop_q - CNT_ONE;
                        state_d = PRGA_IJ;
                    end else begin
                        ks_byte_d  = s_t;
                        ks_valid_d = 1'b1;
                        state_d    = PRGA_OUT;
                    end
                end
                PRGA_OUT: begin
                    if (ks_ready) begin
                        ks_valid_d = 1'b0;
                        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
                        if ((num_q != '0) && (cnt_d == num_q)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = PRGA_IJ;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    ks_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            t_q        <= 8'd0;
            kidx_q     <= '0;
            key_len_q  <= 9'd0;
            drop_q     <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            key_q      <= '{default: 8'h00};
            ks_valid_q <= 1'b0;
            ks_byte_q  <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            t_q        <= t_d;
            kidx_q     <= kidx_d;
            key_len_q  <= key_len_d;
            drop_q     <= drop_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            ks_valid_q <= ks_valid_d;
            ks_byte_q  <= ks_byte_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ks_valid = ks_valid_q;
    assign ks_byte  = ks_byte_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rc4_stream_core.sv
// Directed bench for rc4_stream_core: known RC4 vectors via a byte
// scoreboard, latency, drop, stalls, illegal start, abort and reset.
module tb_rc4_stream_core;

    localparam int KMAX = 16;
    localparam int CW   = 16;
    localparam int KW   = $clog2(KMAX);

    localparam logic [7:0] KS_KEY  [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                                           8'h34, 8'hCA, 8'h72, 8'hA7};
    localparam logic [7:0] KS_WIKI [5] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_we;
    logic [KW-1:0] key_waddr;
    logic [7:0]    key_wdata;
    logic [8:0]    key_len;
    logic [CW-1:0] drop_n;
    logic [CW-1:0] num_bytes;
    logic          start;
    logic          abort;
    logic          ks_valid;
    logic          ks_ready;
    logic [7:0]    ks_byte;
    logic          busy;
    logic          done;
    logic          err;

    int         n_assert  = 0;
    int         n_fail    = 0;
    int         remaining = 0;
    int         done_cnt  = 0;
    int         d0;
    int         e;
    bit         mon_en    = 1'b0;
    bit         exp_done  = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] byte_prev = 8'h00;
    logic [7:0] sb [$];

    rc4_stream_core #(.KEY_MAX_BYTES(KMAX), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_we    (key_we),
        .key_waddr (key_waddr),
        .key_wdata (key_wdata),
        .key_len   (key_len),
        .drop_n    (drop_n),
        .num_bytes (num_bytes),
        .start     (start),
        .abort     (abort),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .ks_byte   (ks_byte),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_key(input int a, input logic [7:0] d);
        key_we    = 1'b1;
        key_waddr = KW'(a);
        key_wdata = d;
        step();
        key_we    = 1'b0;
    endtask

    task automatic load_key_key();
        wr_key(0, 8'h4B);
        wr_key(1, 8'h65);
        wr_key(2, 8'h79);
    endtask

    task automatic go(input int len, input int drp, input int num);
        key_len   = 9'(len);
        drop_n    = CW'(drp);
        num_bytes = CW'(num);
        remaining = num;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_valid(input int exp_edges, input string tag);
        int n = 0;
        while (!ks_valid && n < 2000) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_edges));
    endtask

    task automatic wait_idle(input bit rnd, input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            if (rnd) ks_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        ks_ready = 1'b1;
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("done_pulse", 32'(done), 32'(exp_done));
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (stall_prev) begin
                chk("hold_valid", 32'(ks_valid), 32'd1);
                chk("hold_byte", 32'(ks_byte), 32'(byte_prev));
            end
            stall_prev = ks_valid && !ks_ready && !abort && rst_n;
            byte_prev  = ks_byte;
            if (ks_valid && ks_ready && !abort && rst_n) begin
                n_assert++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_byte: observed %02h expected none", ks_byte);
                end
                if (sb.size() != 0) chk("ks_byte", 32'(ks_byte), 32'(sb.pop_front()));
                if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) exp_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; key_we = 1'b0; key_waddr = '0; key_wdata = 8'h00;
        key_len = 9'd0; drop_n = '0; num_bytes = '0;
        start = 1'b0; abort = 1'b0; ks_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_valid", 32'(ks_valid), 32'd0);
        chk("rst_byte",  32'(ks_byte),  32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_err",   32'(err),      32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        mon_en = 1'b1;

        // "Key", 9 bytes, latency 516
        load_key_key();
        for (int k = 0; k < 9; k++) sb.push_back(KS_KEY[k]);
        d0 = done_cnt;
        go(3, 0, 9);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_valid(516, "key_latency");
        wait_idle(1'b0, "key_idle");
        step();
        chk("key_done_count", 32'(done_cnt - d0), 32'd1);
        chk("key_sb_empty", 32'(sb.size()), 32'd0);

        // "Wiki", ready held high, then random back-pressure
        wr_key(0, 8'h57); wr_key(1, 8'h69); wr_key(2, 8'h6B); wr_key(3, 8'h69);
        for (int k = 0; k < 5; k++) sb.push_back(KS_WIKI[k]);
        d0 = done_cnt;
        go(4, 0, 5);
        wait_idle(1'b0, "wiki_idle");
        step();
        chk("wiki_done_count", 32'(done_cnt - d0), 32'd1);
        chk("wiki_sb_empty", 32'(sb.size()), 32'd0);

        for (int k = 0; k < 5; k++) sb.push_back(KS_WIKI[k]);
        d0 = done_cnt;
        go(4, 0, 5);
        wait_idle(1'b1, "wiki_rnd_idle");
        step();
        chk("wiki_rnd_done_count", 32'(done_cnt - d0), 32'd1);
        chk("wiki_rnd_sb_empty", 32'(sb.size()), 32'd0);

        // drop 3
        load_key_key();
        sb.push_back(KS_KEY[3]);
        sb.push_back(KS_KEY[4]);
        d0 = done_cnt;
        go(3, 3, 2);
        wait_valid(525, "drop_latency");
        wait_idle(1'b0, "drop_idle");
        step();
        chk("drop_done_count", 32'(done_cnt - d0), 32'd1);
        chk("drop_sb_empty", 32'(sb.size()), 32'd0);

        // illegal starts
        go(0, 0, 1);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        step();
        chk("len0_err_clear", 32'(err), 32'd0);
        chk("len0_valid", 32'(ks_valid), 32'd0);
        go(17, 0, 1);
        chk("len17_err", 32'(err), 32'd1);
        chk("len17_busy", 32'(busy), 32'd0);
        step();
        chk("len17_err_clear", 32'(err), 32'd0);
        chk("len17_busy2", 32'(busy), 32'd0);

        // abort during KSA
        d0 = done_cnt;
        go(3, 0, 9);
        repeat (100) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ksa_busy", 32'(busy), 32'd0);
        chk("abort_ksa_valid", 32'(ks_valid), 32'd0);
        repeat (5) step();
        chk("abort_ksa_busy_stays", 32'(busy), 32'd0);

        // abort while byte 3 is offered with ready high
        for (int k = 0; k < 9; k++) sb.push_back(KS_KEY[k]);
        go(3, 0, 9);
        e = 0;
        while (sb.size() > 7 && e < 2000) begin step(); e++; end
        e = 0;
        while (!ks_valid && e < 50) begin step(); e++; end
        chk("abort_out_valid_seen", 32'(ks_valid), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_out_valid", 32'(ks_valid), 32'd0);
        chk("abort_out_busy", 32'(busy), 32'd0);
        chk("abort_out_sb_left", 32'(sb.size()), 32'd7);
        sb.delete();
        repeat (3) step();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // clean restart
        for (int k = 0; k < 9; k++) sb.push_back(KS_KEY[k]);
        d0 = done_cnt;
        go(3, 0, 9);
        wait_valid(516, "restart_latency");
        wait_idle(1'b0, "restart_idle");
        step();
        chk("restart_done_count", 32'(done_cnt - d0), 32'd1);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

        // key writes while busy ignored; reset mid-PRGA
        for (int k = 0; k < 9; k++) sb.push_back(KS_KEY[k]);
        d0 = done_cnt;
        go(3, 0, 0);
        repeat (10) step();
        wr_key(0, 8'h00);
        wr_key(1, 8'hFF);
        e = 0;
        while (sb.size() > 4 && e < 3000) begin step(); e++; end
        chk("busy_write_bytes", 32'(sb.size()), 32'd4);
        chk("unlimited_no_done", 32'(done_cnt - d0), 32'd0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 32'(ks_valid), 32'd0);
        chk("mid_rst_byte",  32'(ks_byte),  32'd0);
        chk("mid_rst_done",  32'(done),     32'd0);
        chk("mid_rst_err",   32'(err),      32'd0);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        rst_n = 1'b1;
        sb.delete();
        step();

        load_key_key();
        sb.push_back(KS_KEY[0]);
        sb.push_back(KS_KEY[1]);
        d0 = done_cnt;
        go(3, 0, 2);
        wait_idle(1'b0, "post_rst_idle");
        step();
        chk("post_rst_done_count", 32'(done_cnt - d0), 32'd1);
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_stream_core.md
Name: rc4_stream_core

Overview:
Parametrised RC4 keystream generator. It replaces the fixed 4-byte-key, fixed-length design with these features:
- byte-serial key load, key length 1..KEY_MAX_BYTES;
- RC4-drop[n] discard of the first n keystream bytes;
- programmable byte count, or free-running;
- valid/ready keystream output.

It sits between the key-management logic and the downstream XOR/cipher datapath.

Parameters:
KEY_MAX_BYTES, 16, maximum key length in bytes (2..256).
CNT_W, 16, width of the byte-count and drop-count inputs.

Ports:
clk  in  1  clock.
rst_n  in  1  reset: synchronous, active-low; clock clk.
key_we  in  1  key byte write strobe; honoured only while busy=0.
key_waddr  in  clog2(KEY_MAX_BYTES)  key byte index.
key_wdata  in  8  key byte value.
key_len  in  9  key length in bytes; sampled on start.
drop_n  in  CNT_W  number of initial keystream bytes to discard; sampled on start.
num_bytes  in  CNT_W  number of bytes to emit; 0 = unlimited. Sampled on start.
start  in  1  start request; honoured in IDLE only.
abort  in  1  cancel the current operation.
ks_valid  out  1  keystream byte valid.
ks_ready  in  1  downstream accepts byte.
ks_byte  out  8  keystream byte.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the final counted byte is accepted.
err  out  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset: state=IDLE. ks_valid=0, ks_byte=0, done=0, err=0, busy=0. i=j=0, all key registers=0. S-box contents are don't-care until INIT.
- IDLE:
  - start with key_len==0 or key_len>KEY_MAX_BYTES: err pulses for 1 cycle; state stays IDLE.
  - Otherwise: latch key_len, drop_n and num_bytes; go to INIT.
- INIT (1 cycle): S[n]=n for all n; i=j=0; kidx=0 → KSA_J.
- KSA_J: j <= j + S[i] + K[kidx] (mod 256) → KSA_SWAP.
- KSA_SWAP:
  - Swap S[i] and S[j].
  - kidx increments and wraps to 0 at key_len-1. No modulo divider is used.
  - i increments. When i==255, set i=j=0 and go to PRGA_IJ; otherwise go to KSA_J.
  - KSA therefore takes exactly 512 cycles.
- PRGA_IJ: i <= i+1; j <= j + S[i+1] → PRGA_SWAP.
- PRGA_SWAP: swap S[i] and S[j]; t_reg <= S[i]+S[j], using pre-swap values → PRGA_T.
- PRGA_T:
  - If drop count > 0: decrement it; no output; go to PRGA_IJ.
  - Else: ks_byte <= S[t_reg], reading post-swap contents; ks_valid <= 1; go to PRGA_OUT.
- PRGA_OUT:
  - ks_valid and ks_byte are held stable until ks_ready.
  - On a handshake, ks_valid <= 0 and the emitted-byte counter increments.
  - If num_bytes!=0 and the counter reaches num_bytes: done pulses in the next cycle; go to IDLE. Otherwise go to PRGA_IJ.
- Throughput: 4 cycles/byte with ks_ready held high. Each dropped byte costs 3 cycles.
- Latency: with drop_n=0, ks_valid rises on the 516th rising edge after the edge that samples start.
- abort: from any non-IDLE state, go to IDLE on the next edge. ks_valid is cleared, no done pulse, and abort has priority over a same-cycle handshake. abort in IDLE has no effect. start while busy is ignored.
- key_we while busy: ignored, so the key is stable for the whole KSA.
- A mid-operation rst_n=0 behaves as full reset on the next edge.
- All i, j, t and S arithmetic is 8-bit modulo 256.
- The counters saturate-compare at the CNT_W width. num_bytes=0 never produces done.

Decomposition:
- Package rc4_pkg holds the state enum (IDLE, INIT, KSA_J, KSA_SWAP, PRGA_IJ, PRGA_SWAP, PRGA_T, PRGA_OUT) and the constant SBOX_DEPTH=256.
- Sub-module rc4_sbox is a 256x8 register file with:
  - a synchronous init (identity load);
  - three combinational read ports (i-side, j-side, t);
  - a two-address swap write, where both writes commit on the same edge.

Test Plan:
- Key "Key" (4B 65 79), key_len=3, drop_n=0, num_bytes=9, ks_ready=1 → bytes EB 9F 77 81 B7 34 CA 72 A7. First ks_valid on edge 516; done 1 cycle after byte 9.
- Key "Wiki" (57 69 6B 69), key_len=4, num_bytes=5 → 60 44 DB 6D 41. Then ks_ready toggled randomly → same bytes, ks_byte stable while ks_valid && !ks_ready.
- Key "Key", drop_n=3, num_bytes=2 → emits 81 B7 only. First ks_valid on edge 516+9=525.
- start with key_len=0, and separately with key_len=17 (default parameter) → one-cycle err pulse, busy stays 0, no ks_valid.
- abort asserted during KSA, and again during PRGA_OUT with ks_ready=1 → IDLE next cycle, ks_valid=0, no done. A restart then reproduces the clean "Key" sequence.
- key_we during busy, plus rst_n low mid-PRGA → key unchanged by the write; after reset all outputs 0 and state IDLE.
